// File: rtl/store_merge_unit_pkg.sv
// Shared types for the store merge unit: store opcodes, FSM encoding and the request-reject rule.
package store_merge_unit_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  // A request is rejected when it is misaligned for its size or uses the reserved opcode.
  function automatic logic req_reject(input logic [1:0] op, input logic [1:0] lo);
    logic rej;
    rej = 1'b1;
    case (op)
      ST_SW:   rej = (lo != 2'b00);
      ST_SH:   rej = lo[0];
      ST_SB:   rej = 1'b0;
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request and word-memory signals of the store merge unit.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready are both 1.
interface store_merge_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rvalid, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rvalid, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian lane select: overlays the byte/half being stored onto the old memory word.
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [1:0]    op_i,
  input  logic [1:0]    lane_i,
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (op_i)
      ST_SB: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      ST_SH: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: sw written directly, sb/sh done as read-modify-write on a word-only memory.
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  store_merge_unit_if.slave  bus,
  output logic               done_o,
  output logic               addr_err_o,
  output state_e             state_o
);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   mdata_q, mdata_d;
  logic            err_q, err_d;
  logic [DW-1:0]   merged;

  store_lane_merge u_merge (
    .op_i     (op_q),
    .lane_i   (addr_q[1:0]),
    .old_i    (bus.mem_rdata),
    .wdata_i  (wdata_q),
    .merged_o (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Rejected requests leave the request registers alone so mem_addr stays put.
          if (req_reject(bus.req_op, bus.req_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            op_d    = bus.req_op;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            if (bus.req_op == ST_SW) begin
              mdata_d = bus.req_wdata;
              state_d = WRITE;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          mdata_d = merged;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_re    = (state_q == RD_WAIT);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign bus.mem_wdata = mdata_q;
  assign done_o        = (state_q == WRITE);
  assign addr_err_o    = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: sw, sb/sh read-modify-write, rejects, reset abort, back-to-back.
module tb_store_merge_unit;
  import store_merge_unit_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   done;
  logic   addr_err;
  state_e st;
  int     tests_run;
  int     tests_failed;

  store_merge_unit_if #(.AW(32), .DW(32)) bus ();

  store_merge_unit #(.AW(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus.slave),
    .done_o     (done),
    .addr_err_o (addr_err),
    .state_o    (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  logic [1:0]  rej_op   [3];
  logic [31:0] rej_addr [3];

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rej_op   = '{2'b01, 2'b00, 2'b11};
    rej_addr = '{32'h21, 32'h02, 32'h30};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    rst_n = 1'b1;
    tick();

    // sw: write one cycle after accept, no read
    drive_req(2'b00, 32'h10, 32'hDEADBEEF);
    chk("sw_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("sw_we", {31'd0, bus.mem_we}, 32'd1);
    chk("sw_done", {31'd0, done}, 32'd1);
    chk("sw_addr", bus.mem_addr, 32'h10);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_re", {31'd0, bus.mem_re}, 32'd0);
    chk("sw_state", {30'd0, st}, 32'd2);
    tick();
    chk("sw_we_off", {31'd0, bus.mem_we}, 32'd0);
    chk("sw_done_off", {31'd0, done}, 32'd0);
    chk("sw_re_off", {31'd0, bus.mem_re}, 32'd0);
    chk("sw_ready_back", {31'd0, bus.req_ready}, 32'd1);

    // sb lane 3, read data after three mem_re cycles
    drive_req(2'b10, 32'h13, 32'h000000AA);
    tick();
    bus.req_valid = 1'b0;
    chk("sb_re", {31'd0, bus.mem_re}, 32'd1);
    chk("sb_addr", bus.mem_addr, 32'h10);
    chk("sb_ready", {31'd0, bus.req_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sb_re_hold", {31'd0, bus.mem_re}, 32'd1);
      chk("sb_we_wait", {31'd0, bus.mem_we}, 32'd0);
      chk("sb_addr_hold", bus.mem_addr, 32'h10);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11223344;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    chk("sb_we", {31'd0, bus.mem_we}, 32'd1);
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_re_off", {31'd0, bus.mem_re}, 32'd0);
    chk("sb_wdata", bus.mem_wdata, 32'hAA223344);
    chk("sb_addr_wr", bus.mem_addr, 32'h10);
    tick();
    chk("sb_we_off", {31'd0, bus.mem_we}, 32'd0);

    // sh upper half, rvalid on first mem_re cycle
    drive_req(2'b01, 32'h22, 32'h00005566);
    tick();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11223344;
    chk("sh_re", {31'd0, bus.mem_re}, 32'd1);
    chk("sh_addr", bus.mem_addr, 32'h20);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("sh_we", {31'd0, bus.mem_we}, 32'd1);
    chk("sh_wdata", bus.mem_wdata, 32'h55663344);
    chk("sh_addr_wr", bus.mem_addr, 32'h20);
    tick();
    chk("sh_we_off", {31'd0, bus.mem_we}, 32'd0);

    // sh lower half
    drive_req(2'b01, 32'h24, 32'h0000ABCD);
    tick();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11223344;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("shlo_wdata", bus.mem_wdata, 32'h1122ABCD);
    chk("shlo_addr", bus.mem_addr, 32'h24);
    tick();

    // rejects: misaligned sh, misaligned sw, reserved op
    for (int i = 0; i < 3; i++) begin
      drive_req(rej_op[i], rej_addr[i], 32'hFFFFFFFF);
      tick();
      bus.req_valid = 1'b0;
      chk("rej_err", {31'd0, addr_err}, 32'd1);
      chk("rej_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rej_re", {31'd0, bus.mem_re}, 32'd0);
      chk("rej_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rej_addr_held", bus.mem_addr, 32'h24);
      tick();
      chk("rej_err_off", {31'd0, addr_err}, 32'd0);
      chk("rej_we_after", {31'd0, bus.mem_we}, 32'd0);
    end

    // reset while in RD_WAIT aborts the pending store
    drive_req(2'b10, 32'h50, 32'h00000077);
    tick();
    bus.req_valid = 1'b0;
    chk("abort_re", {31'd0, bus.mem_re}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_re_off", {31'd0, bus.mem_re}, 32'd0);
    chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_state", {30'd0, st}, 32'd0);
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_we", {31'd0, bus.mem_we}, 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_idle_we", {31'd0, bus.mem_we}, 32'd0);
    drive_req(2'b00, 32'h54, 32'h12345678);
    tick();
    bus.req_valid = 1'b0;
    chk("post_rst_we", {31'd0, bus.mem_we}, 32'd1);
    chk("post_rst_wdata", bus.mem_wdata, 32'h12345678);
    chk("post_rst_addr", bus.mem_addr, 32'h54);
    tick();

    // back-to-back sw, sb, sw with req_valid held high
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCCCCCCCC;
    drive_req(2'b00, 32'h40, 32'h01020304);
    tick();
    chk("b2b1_done", {31'd0, done}, 32'd1);
    chk("b2b1_wdata", bus.mem_wdata, 32'h01020304);
    chk("b2b1_addr", bus.mem_addr, 32'h40);
    drive_req(2'b10, 32'h41, 32'h000000BB);
    tick();
    chk("b2b2_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b2_idle_done", {31'd0, done}, 32'd0);
    tick();
    chk("b2b2_re", {31'd0, bus.mem_re}, 32'd1);
    chk("b2b2_we_off", {31'd0, bus.mem_we}, 32'd0);
    drive_req(2'b00, 32'h44, 32'hCAFEF00D);
    tick();
    chk("b2b2_done", {31'd0, done}, 32'd1);
    chk("b2b2_wdata", bus.mem_wdata, 32'hCCCCBBCC);
    chk("b2b2_addr", bus.mem_addr, 32'h40);
    tick();
    chk("b2b3_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid  = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("b2b3_done", {31'd0, done}, 32'd1);
    chk("b2b3_wdata", bus.mem_wdata, 32'hCAFEF00D);
    chk("b2b3_addr", bus.mem_addr, 32'h44);
    tick();
    chk("b2b_end_idle", {30'd0, st}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
